// File: rtl/capture_pkg.sv
// Shared definitions for the logic-analyzer capture buffer.
// State encoding and read pipeline depth.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int READ_LATENCY = 2;

endpackage

// File: rtl/capture_dpram.sv
// Simple dual-port block RAM: write port A, registered read port B.
// Read data holds its value when no read is enabled.
module capture_dpram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    (* ram_style = "AUTO" *)
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_readout_buffer.sv
// Circular pre/post-trigger capture memory with oldest-first readout.
// FSM, pointers and the two-stage read pipeline live here.
module capture_readout_buffer
    import capture_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIN,
    input  logic             ARM,
    input  logic             TRIG,
    input  logic [15:0]      POST_CNT,
    input  logic             RD_REQ,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             RD_VALID,
    output logic             RD_LAST,
    output logic             DONE,
    output logic             BUSY,
    output logic [15:0]      TRIG_POS
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);
    localparam logic [15:0] PE_MAX  = 16'(DEPTH - 1);

    state_t state, state_n;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_addr;
    logic [15:0]       fill, post_left, pe, rd_left;
    logic [READ_LATENCY-1:0] vpipe, lpipe;

    logic              in_done, arm_done, wr_en;
    logic              trig_hit, post_end, rd_acc;
    logic              enter_armed, enter_done;
    logic [15:0]       pe_new, pe_eff, fill_wr;
    logic [ADDR_W-1:0] wr_ptr_wr;

    assign in_done  = (state == ST_DONE);
    assign arm_done = in_done && ARM;
    assign wr_en    = CE && (state == ST_ARMED || state == ST_POST);
    assign trig_hit = CE && TRIG && (state == ST_ARMED);
    assign post_end = CE && (state == ST_POST) && (post_left == 16'd1);
    assign rd_acc   = in_done && !ARM && RD_REQ && (rd_left != 16'd0);

    assign pe_new    = (POST_CNT > PE_MAX) ? PE_MAX : POST_CNT;
    assign pe_eff    = trig_hit ? pe_new : pe;
    assign fill_wr   = (fill == DEPTH16) ? fill : fill + 16'd1;
    assign wr_ptr_wr = wr_ptr + ADDR_W'(1);

    assign enter_armed = (state_n == ST_ARMED) && (state != ST_ARMED);
    assign enter_done  = (state_n == ST_DONE) && !in_done;

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:  if (ARM) state_n = ST_ARMED;
            ST_ARMED: begin
                if (trig_hit) begin
                    state_n = (pe_new == 16'd0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST:  if (post_end) state_n = ST_DONE;
            ST_DONE:  if (ARM) state_n = ST_ARMED;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            fill      <= '0;
            post_left <= '0;
            pe        <= '0;
            rd_ptr    <= '0;
            rd_left   <= '0;
            rd_addr   <= '0;
            TRIG_POS  <= '0;
            vpipe     <= '0;
            lpipe     <= '0;
        end else begin
            if (enter_armed) begin
                wr_ptr <= '0;
                fill   <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr_wr;
                fill   <= fill_wr;
            end

            if (trig_hit) begin
                pe        <= pe_new;
                post_left <= pe_new;
            end else if (wr_en && state == ST_POST) begin
                post_left <= post_left - 16'd1;
            end

            // The final write lands on the entry cycle, so use post-write values
            if (enter_done) begin
                rd_ptr   <= (fill_wr == DEPTH16) ? wr_ptr_wr : '0;
                rd_left  <= fill_wr;
                TRIG_POS <= fill_wr - pe_eff - 16'd1;
            end else if (rd_acc) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                rd_left <= rd_left - 16'd1;
            end

            if (rd_acc) begin
                rd_addr <= rd_ptr;
            end

            if (arm_done) begin
                vpipe <= '0;
                lpipe <= '0;
            end else begin
                vpipe <= {vpipe[READ_LATENCY-2:0], rd_acc};
                lpipe <= {lpipe[READ_LATENCY-2:0],
                          rd_acc && (rd_left == 16'd1)};
            end
        end
    end

    capture_dpram #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (CLK),
        .rst   (RST),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (DIN),
        .re    (vpipe[0]),
        .raddr (rd_addr),
        .rdata (RD_DATA)
    );

    // Re-arm kills in-flight responses in the same cycle
    assign RD_VALID = vpipe[READ_LATENCY-1] && !arm_done;
    assign RD_LAST  = lpipe[READ_LATENCY-1] && !arm_done;
    assign DONE     = in_done;
    assign BUSY     = (state == ST_ARMED) || (state == ST_POST);

endmodule
